// File: rtl/uart_tx_scheduler_if.sv
// APB slave bus plus transmitter start/done handshake for uart_tx_scheduler.
// The slave modport is the scheduler's view; master is the view of whoever drives it.
interface uart_tx_scheduler_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_done,
        output PRDATA, PREADY, PSLVERR, tx_start, tx_data
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_done,
        input  PRDATA, PREADY, PSLVERR, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// APB-fed TX FIFO that hands bytes one at a time to a UART transmitter via
// a start/done handshake, with status/control registers and a level interrupt.
module uart_tx_scheduler #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    uart_tx_scheduler_if.slave bus,
    output logic               irq
);
    localparam int unsigned     PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr    = PtrW'(DEPTH - 1);
    localparam logic [3:0]      DepthCnt   = 4'(DEPTH);
    localparam logic [7:0]      GapLast    = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]      AddrData   = 8'h00;
    localparam logic [7:0]      AddrStatus = 8'h01;
    localparam logic [7:0]      AddrCtrl   = 8'h02;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            ovf_q, ovf_d;
    logic            en_q, en_d;
    logic            irq_en_q, irq_en_d;
    logic            irq_q, irq_d;

    logic access, sel_data, sel_status, sel_ctrl, mapped;
    logic wr_data, wr_ctrl, empty, full, busy, push, pop;
    logic [7:0] status;

    // APB decode: zero wait states, every access completes in its access phase.
    assign access     = bus.PSEL & bus.PENABLE;
    assign sel_data   = (bus.PADDR == AddrData);
    assign sel_status = (bus.PADDR == AddrStatus);
    assign sel_ctrl   = (bus.PADDR == AddrCtrl);
    assign mapped     = sel_data | sel_status | sel_ctrl;
    assign wr_data    = access & bus.PWRITE & sel_data;
    assign wr_ctrl    = access & bus.PWRITE & sel_ctrl;

    assign empty  = (count_q == 4'd0);
    assign full   = (count_q == DepthCnt);
    assign busy   = (state_q != StIdle);
    assign push   = wr_data & ~full;
    assign pop    = (state_q == StIdle) & en_q & ~empty;
    assign status = {count_q, ovf_q, busy, full, empty};

    assign bus.PREADY   = access;
    assign bus.PSLVERR  = access & ~mapped;
    assign bus.tx_start = (state_q == StStart);
    assign bus.tx_data  = tx_data_q;
    assign irq          = irq_q;

    always_comb begin
        bus.PRDATA = 8'h00;
        if (access && !bus.PWRITE) begin
            if (sel_status) begin
                bus.PRDATA = status;
            end else if (sel_ctrl) begin
                bus.PRDATA = {6'd0, irq_en_q, en_q};
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (pop && !push) begin
            count_d = count_q - 4'd1;
        end
        if (wr_ctrl) begin
            en_d     = bus.PWDATA[0];
            irq_en_d = bus.PWDATA[1];
        end
        // A dropped push outranks a simultaneous clear request.
        if (wr_data && full) begin
            ovf_d = 1'b1;
        end else if (wr_ctrl && bus.PWDATA[2]) begin
            ovf_d = 1'b0;
        end
        irq_d = irq_en_q & ((empty & ~busy) | ovf_q);
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (bus.tx_done) begin
                    gap_cnt_d = 8'd0;
                    state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.PWDATA;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            tx_data_q <= 8'h00;
            gap_cnt_q <= 8'd0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            gap_cnt_q <= gap_cnt_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: APB stimulus pushes expected bytes into a
// scoreboard queue; a monitor checks every launched frame against it.
module tb_uart_tx_scheduler;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned FRAME = 6;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;
    logic irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] held;
    bit         in_frame, prev_start, have_done;
    bit         auto_done = 1'b1;
    bit         done_req  = 1'b0;
    int         last_done_cyc, start_cnt, acc_cyc;
    int         s0, t_acc, t_done;
    logic [7:0] rd;
    logic       err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard for the transmitter side.
    initial begin
        forever begin
            @(negedge PCLK); #1;
            if (PRESET) begin
                in_frame   = 1'b0;
                prev_start = 1'b0;
                have_done  = 1'b0;
            end else begin
                if (bus.tx_start) begin
                    chk("start_pulse_width", 32'(prev_start), 32'(0));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_start: got tx_data 0x%0h, expected no frame",
                                 bus.tx_data);
                    end else begin
                        chk("tx_data_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    end
                    if (have_done) chk("frame_spacing", 32'(cyc - last_done_cyc), 32'(GAP + 2));
                    held     = bus.tx_data;
                    in_frame = 1'b1;
                    start_cnt++;
                end
                if (bus.tx_done && in_frame) begin
                    chk("tx_data_hold", 32'(bus.tx_data), 32'(held));
                    in_frame      = 1'b0;
                    last_done_cyc = cyc;
                    have_done     = 1'b1;
                end
                prev_start = bus.tx_start;
            end
        end
    end

    // Transmitter model: done pulse FRAME cycles after start, or on request.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge PCLK); #1;
            if (done_req) begin
                done_req = 1'b0;
                @(negedge PCLK);
                bus.tx_done = 1'b1;
                @(negedge PCLK);
                bus.tx_done = 1'b0;
            end else if (bus.tx_start && auto_done && !PRESET) begin
                repeat (FRAME) @(negedge PCLK);
                bus.tx_done = 1'b1;
                @(negedge PCLK);
                bus.tx_done = 1'b0;
            end
        end
    end

    task automatic apb(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       output logic [7:0] rdata, output logic perr);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        acc_cyc = cyc;
        rdata   = bus.PRDATA;
        perr    = bus.PSLVERR;
        chk("pready", 32'(bus.PREADY), 32'(1));
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] r;
        logic       e;
        apb(1'b1, addr, data, r, e);
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] r;
        logic       e;
        apb(1'b0, addr, 8'h00, r, e);
        chk(name, 32'(r), 32'(exp));
        chk({name, "_slverr"}, 32'(e), 32'(0));
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        write_reg(8'h00, b);
    endtask

    task automatic wait_for(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge PCLK); #1;
            case (which)
                0:       seen = bus.tx_start;
                1:       seen = bus.tx_done;
                default: seen = irq;
            endcase
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: got no event, expected one within 200 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge PCLK); #1;
            done = (exp_q.size() == 0) && !in_frame;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: got %0d bytes pending, expected 0", name, exp_q.size());
        end
        repeat (GAP + 3) @(negedge PCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 8'h00;
        repeat (3) @(negedge PCLK); #1;
        chk("rst_tx_start", 32'(bus.tx_start), 32'(0));
        chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
        chk("rst_irq", 32'(irq), 32'(0));
        chk("rst_pready", 32'(bus.PREADY), 32'(0));
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'(0));
        chk("rst_prdata", 32'(bus.PRDATA), 32'(0));
        @(negedge PCLK); PRESET = 1'b0;
        @(negedge PCLK);
        read_chk("status_after_reset", 8'h01, 8'h01);
        read_chk("ctrl_after_reset", 8'h02, 8'h00);

        // Reset in the middle of a frame flushes everything.
        auto_done = 1'b0;
        write_reg(8'h02, 8'h01);
        push_byte(8'hA5, 1'b1);
        wait_for(0, "a5_start");
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1; #1;
        chk("midrst_tx_start", 32'(bus.tx_start), 32'(0));
        chk("midrst_tx_data", 32'(bus.tx_data), 32'(0));
        chk("midrst_irq", 32'(irq), 32'(0));
        @(negedge PCLK); PRESET = 1'b0;
        @(negedge PCLK);
        read_chk("status_flushed", 8'h01, 8'h01);
        read_chk("ctrl_cleared", 8'h02, 8'h00);
        s0 = start_cnt;
        write_reg(8'h02, 8'h01);
        done_req = 1'b1;
        repeat (20) @(negedge PCLK);
        chk("no_start_after_reset", 32'(start_cnt), 32'(s0));
        auto_done = 1'b1;

        // Single byte: latency and return to idle.
        write_reg(8'h02, 8'h03);
        repeat (2) @(negedge PCLK); #1;
        chk("irq_idle_empty", 32'(irq), 32'(1));
        push_byte(8'h3C, 1'b1);
        t_acc = acc_cyc;
        wait_for(0, "3c_start");
        chk("start_latency", 32'(cyc - t_acc), 32'(2));
        wait_for(1, "3c_done");
        t_done = cyc;
        wait_for(2, "3c_irq_back");
        chk("idle_irq_after_done", 32'(cyc - t_done), 32'(GAP + 2));
        read_chk("status_single_end", 8'h01, 8'h01);
        have_done = 1'b0;

        // Burst of DEPTH bytes queued while disabled.
        write_reg(8'h02, 8'h00);
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
        read_chk("status_full", 8'h01, 8'h82);
        s0 = start_cnt;
        write_reg(8'h02, 8'h01);
        drain("burst_drain");
        chk("burst_frames", 32'(start_cnt - s0), 32'(8));
        read_chk("status_burst_end", 8'h01, 8'h01);
        have_done = 1'b0;

        // Overflow: ninth byte dropped, sticky flag, clear.
        write_reg(8'h02, 8'h02);
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), i < 8);
        read_chk("status_ovf", 8'h01, 8'h8A);
        chk("irq_ovf", 32'(irq), 32'(1));
        write_reg(8'h02, 8'h07);
        read_chk("status_ovf_clr", 8'h01, 8'h74);
        chk("irq_after_clr", 32'(irq), 32'(0));
        drain("ovf_drain");
        read_chk("status_ovf_end", 8'h01, 8'h01);
        chk("irq_empty_again", 32'(irq), 32'(1));
        read_chk("ctrl_readback", 8'h02, 8'h03);
        have_done = 1'b0;

        // Push lands on the same edge as the pop of the last queued byte.
        push_byte(8'h50, 1'b1);
        push_byte(8'h55, 1'b1);
        wait_for(1, "50_done");
        repeat (GAP) @(negedge PCLK);
        push_byte(8'h66, 1'b1);
        read_chk("status_push_pop", 8'h01, 8'h14);
        drain("pushpop_drain");
        read_chk("status_pushpop_end", 8'h01, 8'h01);
        have_done = 1'b0;

        // Unmapped and read-only accesses.
        apb(1'b0, 8'h05, 8'h00, rd, err);
        chk("unmapped_rd_err", 32'(err), 32'(1));
        chk("unmapped_rd_data", 32'(rd), 32'(0));
        apb(1'b1, 8'h05, 8'h00, rd, err);
        chk("unmapped_wr_err", 32'(err), 32'(1));
        read_chk("ctrl_unchanged", 8'h02, 8'h03);
        read_chk("status_unchanged", 8'h01, 8'h01);
        apb(1'b1, 8'h01, 8'hFF, rd, err);
        chk("status_wr_err", 32'(err), 32'(0));
        read_chk("status_after_wr", 8'h01, 8'h01);
        read_chk("data_reads_zero", 8'h00, 8'h00);
        repeat (5) @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
APB-slave front end that buffers bytes written by the APB master into a small TX FIFO. It sequences them one at a time into the uart_transmitter using a start/done handshake. It sits between the APB bus (PSEL2 decode) and the transmitter core, and provides status, control and a completion interrupt.

Parameters:
DEPTH, 8, TX FIFO entries (2..15; occupancy count reported in 4 bits)
GAP_CYCLES, 2, idle PCLK cycles inserted between consecutive frames (0..255)

Ports:
PCLK  input  1  system clock, all logic on rising edge
PRESET  input  1  asynchronous, active-high reset
PSEL  input  1  APB slave select
PENABLE  input  1  APB access phase
PWRITE  input  1  1 = write, 0 = read
PADDR  input  8  register address
PWDATA  input  8  write data
PRDATA  output  8  read data
PREADY  output  1  slave ready
PSLVERR  output  1  error for an unmapped address
tx_start  output  1  one-cycle pulse that launches a frame in the transmitter
tx_data  output  8  byte presented to the transmitter; held stable from tx_start until tx_done
tx_done  input  1  one-cycle pulse from the transmitter at the end of the stop bit
irq  output  1  level interrupt

Behaviour:
- Reset (async, PRESET=1) sets all outputs and state to 0: PRDATA, PREADY, PSLVERR, tx_start, tx_data, irq, FIFO pointers and count, CTRL register, overflow flag. FSM returns to IDLE. Asserting reset mid-frame aborts scheduling and flushes the FIFO; tx_done is ignored until the next tx_start.
- APB access has zero wait states:
  - PREADY = PSEL & PENABLE (combinational).
  - A register access takes effect on the PCLK edge where PSEL & PENABLE = 1.
  - PRDATA is combinational during the access phase and 0 otherwise.
  - PSLVERR = PSEL & PENABLE & (unmapped PADDR). An errored write has no side effect.
- Register map:
  - 0x00 DATA (write-only; reads return 0): a write pushes PWDATA into the FIFO.
  - 0x01 STATUS (read-only; writes ignored, no error), bit fields:
    - bit0 empty
    - bit1 full
    - bit2 busy (FSM not IDLE)
    - bit3 overflow (sticky)
    - bits[7:4] count
  - 0x02 CTRL (read/write):
    - bit0 en
    - bit1 irq_en
    - bit2 clr_ovf: write-1 clears overflow, reads back 0
    - bits[7:3] read back 0
  - Any other address is unmapped.
- FIFO:
  - Push to a full FIFO drops the byte and sets overflow.
  - A push and a pop in the same cycle leave count unchanged; a push to a full FIFO in that cycle is still dropped.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - If overflow set and clr_ovf occur in the same cycle, set wins.
- FSM states and transitions:
  - IDLE: if en=1 and count>0, pop the head into tx_data, go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle, go to WAIT.
  - WAIT: hold tx_data; on tx_done go to GAP (or IDLE if GAP_CYCLES=0). tx_done seen in IDLE or START is ignored.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: a DATA write to an empty FIFO with en=1 produces tx_start 2 cycles after the write edge (write edge → IDLE pop edge → START). Back-to-back frames are spaced tx_done → GAP_CYCLES → IDLE → START, so the next tx_start comes GAP_CYCLES+2 cycles after tx_done.
- Clearing en mid-frame: the current frame completes; no further pops occur. Queued bytes stay in the FIFO.
- irq = irq_en & ((empty & state==IDLE) | overflow), registered (1-cycle lag).

Test Plan:
- Reset mid-frame: push 0xA5, assert PRESET during WAIT → all outputs 0, count=0; no tx_start after release until a new push.
- Single byte: CTRL=0x01, write DATA=0x3C → tx_start pulses 2 cycles later with tx_data=0x3C; after tx_done, STATUS busy falls GAP_CYCLES+1 cycles later.
- Burst: en=0, push 0x01..0x08 → STATUS=0x82 (count 8, full). Set en=1 → 8 tx_start pulses in order 0x01..0x08, each spaced GAP_CYCLES+2 cycles after the preceding tx_done. Final STATUS=0x01.
- Overflow: en=0, push 9 bytes → 9th byte dropped, STATUS bit3=1. With irq_en=1, irq=1. Write CTRL=0x07 → overflow clears, irq follows the empty/idle term.
- Simultaneous push/pop: with count=1 in IDLE and en=1, write DATA on the pop edge → count stays 1, FIFO order preserved.
- APB error: read or write PADDR=0x05 → PSLVERR=1, PRDATA=0, no state change. Write STATUS → PSLVERR=0, no change.
